// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU result producer / writeback consumer and the result buffer.
// The master side drives ALU results in and consumes the head; the slave side is the buffer.
interface alu_result_buffer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:0]   in_result;
    logic [3:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_ovf;

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_ovf
    );
endinterface

// File: rtl/alu_result_buffer.sv
// ALU writeback buffer: optional signed saturation of ADD/SUB overflow, small FIFO
// toward the register file, and a sticky saturating overflow-event counter.
module alu_result_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_buffer_if.slave   bus,
    input  logic                 clr_count,
    output logic [7:0]           ovf_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [3:0]  OP_ADD = 4'b0010;
    localparam logic [3:0]  OP_SUB = 4'b0110;

    // Entry layout: {ovf, zero, data}
    logic [DATA_W+1:0] mem_q [DEPTH];

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              full, empty, push, pop;
    logic              in_ovf, sat_hit;
    logic [DATA_W-1:0] in_data, store_data;
    logic [DATA_W+1:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    // Full blocks push even when the head pops this cycle, keeping in_ready off the out_ready path.
    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;

    assign in_ovf  = bus.in_result[DATA_W];
    assign in_data = bus.in_result[DATA_W-1:0];
    assign sat_hit = SAT_EN && in_ovf && ((bus.in_op == OP_ADD) || (bus.in_op == OP_SUB));

    always_comb begin
        store_data = in_data;
        if (sat_hit) begin
            // Wrapped sign is inverted relative to the true result's direction.
            store_data = in_data[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}}
                                           : {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        if (clr_count) begin
            cnt_d = '0;
        end else if (push && in_ovf && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_ovf, (store_data == '0), store_data};
        end
    end

    // Storage is not reset, so head fields are masked to zero while empty.
    assign head          = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0   : head[DATA_W-1:0];
    assign bus.out_zero  = empty ? 1'b0 : head[DATA_W];
    assign bus.out_ovf   = empty ? 1'b0 : head[DATA_W+1];
    assign ovf_count     = cnt_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed scoreboard bench for alu_result_buffer: expected entries are queued at push
// and compared against the head each cycle it is valid.
module tb_alu_result_buffer;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_UNK = 4'b0011;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              z;
        logic              o;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_count;
    logic [7:0] ovf_count;
    logic [7:0] ovf_count2;

    alu_result_buffer_if #(.DATA_W(DATA_W)) bus ();
    alu_result_buffer_if #(.DATA_W(DATA_W)) bus2 ();

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clr_count(clr_count), .ovf_count(ovf_count)
    );

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAT_EN(1'b0)) dut_nosat (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .clr_count(clr_count), .ovf_count(ovf_count2)
    );

    always #5 clk = ~clk;

    ent_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned exp_cnt  = 0;

    function automatic ent_t model(input logic [DATA_W:0] r, input logic [3:0] op);
        ent_t e;
        e.d = r[DATA_W-1:0];
        e.o = r[DATA_W];
        if (r[DATA_W] && (op == OP_ADD || op == OP_SUB))
            e.d = r[DATA_W-1] ? 16'h7FFF : 16'h8000;
        e.z = (e.d == 16'h0000);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, check and update the model at negedge.
    task automatic cyc(input logic iv, input logic [DATA_W:0] res, input logic [3:0] op,
                       input logic ordy, input logic clr);
        ent_t e;
        bit   do_push, do_pop;
        bus.in_valid  = iv;
        bus.in_result = res;
        bus.in_op     = op;
        bus.out_ready = ordy;
        clr_count     = clr;
        @(negedge clk);
        check("in_ready",  32'(bus.in_ready),  32'(sb.size() < DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
        check("ovf_count", 32'(ovf_count),     exp_cnt);
        if (sb.size() > 0) begin
            check("out_data", 32'(bus.out_data), 32'(sb[0].d));
            check("out_zero", 32'(bus.out_zero), 32'(sb[0].z));
            check("out_ovf",  32'(bus.out_ovf),  32'(sb[0].o));
        end
        do_push = iv && (sb.size() < DEPTH);
        do_pop  = ordy && (sb.size() > 0);
        e = model(res, op);
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(e);
        if (clr) exp_cnt = 0;
        else if (do_push && res[DATA_W] && exp_cnt < 255) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, OP_AND, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        clr_count = 1'b0;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_op = OP_AND; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_result = '0; bus2.in_op = OP_AND; bus2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready",  32'(bus.in_ready),  1);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_out_zero",  32'(bus.out_zero),  0);
        check("rst_out_ovf",   32'(bus.out_ovf),   0);
        check("rst_ovf_count", 32'(ovf_count),     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic push, 1-cycle latency
        cyc(1'b1, {1'b0, 16'h0005}, OP_ADD, 1'b0, 1'b0);
        cyc(1'b0, '0, OP_AND, 1'b1, 1'b0);
        cyc(1'b0, '0, OP_AND, 1'b0, 1'b0);

        // Saturation on ADD/SUB overflow, none on MUL/unknown ops
        cyc(1'b1, {1'b1, 16'h8001}, OP_ADD, 1'b0, 1'b0);
        cyc(1'b1, {1'b1, 16'h7FFE}, OP_SUB, 1'b0, 1'b0);
        cyc(1'b1, {1'b1, 16'h8001}, OP_MUL, 1'b0, 1'b0);
        cyc(1'b1, {1'b1, 16'h8000}, OP_UNK, 1'b0, 1'b0);
        drain();

        // SAT_EN=0 build passes the wrapped value through
        bus2.in_valid = 1'b1; bus2.in_result = {1'b1, 16'h8001}; bus2.in_op = OP_ADD;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("nosat_valid", 32'(bus2.out_valid), 1);
        check("nosat_data",  32'(bus2.out_data),  32'h8001);
        check("nosat_ovf",   32'(bus2.out_ovf),   1);
        check("nosat_count", 32'(ovf_count2),     1);
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;

        // Fill to full, extra push ignored (also with a concurrent pop), drain in order
        for (int i = 0; i < 5; i++) cyc(1'b1, {1'b0, 16'(16'h0100 + i)}, OP_OR(), 1'b0, 1'b0);
        cyc(1'b1, {1'b0, 16'h0BAD}, OP_AND, 1'b1, 1'b0);
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap
        cyc(1'b1, {1'b0, 16'h0200}, OP_ADD, 1'b0, 1'b0);
        cyc(1'b1, {1'b0, 16'h0201}, OP_ADD, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, {1'b0, 16'(16'h0300 + i)}, OP_ADD, 1'b1, 1'b0);
            check("occ_stays_2", 32'(sb.size()), 2);
        end
        drain();

        // Zero flag, counter saturation, clear beats concurrent overflow push
        cyc(1'b1, {1'b0, 16'h0000}, OP_AND, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 300; i++)
            cyc(1'b1, {1'b1, 16'($urandom)}, (i % 2 == 0) ? OP_ADD : OP_MUL, 1'b1, 1'b0);
        drain();
        check("cnt_sat", 32'(ovf_count), 255);
        cyc(1'b1, {1'b1, 16'h8001}, OP_ADD, 1'b0, 1'b1);
        cyc(1'b0, '0, OP_AND, 1'b0, 1'b0);
        drain();

        // Async reset mid-stream with three queued entries
        for (int i = 0; i < 3; i++) cyc(1'b1, {1'b1, 16'(16'h0400 + i)}, OP_AND, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("amid_out_valid", 32'(bus.out_valid), 0);
        check("amid_in_ready",  32'(bus.in_ready),  1);
        check("amid_out_data",  32'(bus.out_data),  0);
        check("amid_ovf_count", 32'(ovf_count),     0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, {1'b0, 16'h0ACE}, OP_ADD, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    function automatic logic [3:0] OP_OR();
        return 4'b0001;
    endfunction
endmodule
